multi_channel_serializer: RTL and testbench

Parametrised successor to the per-kernel fc output serializer. It accepts one parallel column (LAYER_HEIGHT words) from each of NUM_CHANNELS conv kernels through per-channel valid/ready handshakes, buffers each column, and streams the words one at a time onto a single write interface (wen/full). Two ordering modes are supported: channel-major with round-robin channel selection, and position-major interleave across all channels. It sits between the conv_layer bank and the downstream abs/gap/fc stages, replacing N independent serializers.

---
 rtl/serializer_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 23 ++
 rtl/multi_channel_serializer.sv | 77 +++++++
 tb/tb_multi_channel_serializer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// serializer_pkg: shared FSM state, ordering-mode codes and width helper for the serializer
package serializer_pkg;
  typedef enum logic {IDLE, STREAM} state_e;
  localparam int CH_MAJOR = 0;
  localparam int POS_MAJOR = 1;
  function automatic int safe_clog2(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requesting index at or after ptr, wrapping (req, ptr -> grant_idx, grant_valid)
module rr_arbiter
  import serializer_pkg::*;
#(
  parameter int N = 8,
  localparam int W = safe_clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant_idx,
  output logic         grant_valid
);
  int j;
  always_comb begin
    j = 0;
    grant_idx = '0;
    grant_valid = |req;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k >= N ? int'(ptr) + k - N : int'(ptr) + k;
      grant_idx = req[j] ? W'(j) : grant_idx;
    end
  end
endmodule

// File: rtl/multi_channel_serializer.sv
// multi_channel_serializer: per-channel valid/ready column capture streamed as single words on a wen/full port
module multi_channel_serializer
  import serializer_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int LAYER_HEIGHT = 13,
  parameter int WORD_SIZE = 16,
  parameter int INTERLEAVE = 0,
  localparam int CW = safe_clog2(NUM_CHANNELS),
  localparam int IW = safe_clog2(LAYER_HEIGHT)
) (
  input  logic                                                 clk_i,
  input  logic                                                 reset_i,
  input  logic [NUM_CHANNELS-1:0]                              valid_i,
  output logic [NUM_CHANNELS-1:0]                              ready_o,
  input  logic [NUM_CHANNELS-1:0][LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_i,
  output logic                                                 wen_o,
  input  logic                                                 full_i,
  output logic [WORD_SIZE-1:0]                                 data_o,
  output logic [CW-1:0]                                        channel_o,
  output logic [IW-1:0]                                        index_o,
  output logic                                                 last_o
);
  logic [NUM_CHANNELS-1:0][LAYER_HEIGHT-1:0][WORD_SIZE-1:0] col_buf;
  logic [NUM_CHANNELS-1:0] occ, cap, clr;
  logic [CW-1:0] rr_ptr, cur_ch, grant_idx;
  logic [IW-1:0] idx;
  logic grant_valid, xfer, ch_end, idx_end, start;
  state_e state;
  rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .req(occ),
    .ptr(rr_ptr),
    .grant_idx(grant_idx),
    .grant_valid(grant_valid)
  );
  always_comb begin
    ch_end = cur_ch == CW'(NUM_CHANNELS - 1);
    idx_end = idx == IW'(LAYER_HEIGHT - 1);
    ready_o = ~occ & {NUM_CHANNELS{!reset_i}};
    cap = valid_i & ready_o;
    wen_o = state == STREAM;
    last_o = wen_o & idx_end & (INTERLEAVE == CH_MAJOR | ch_end);
    data_o = wen_o ? col_buf[cur_ch][idx] : '0;
    channel_o = cur_ch;
    index_o = idx;
    xfer = wen_o & !full_i;
    clr = !(xfer & last_o) ? '0 : INTERLEAVE == POS_MAJOR ? '1 : NUM_CHANNELS'(1) << cur_ch;
    start = INTERLEAVE == POS_MAJOR ? &occ : grant_valid;
  end
  always_ff @(posedge clk_i)
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (cap[c]) col_buf[c] <= data_i[c];
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      occ <= '0;
      state <= IDLE;
      rr_ptr <= '0;
      idx <= '0;
      cur_ch <= '0;
    end else begin
      occ <= (occ | cap) & ~clr;
      if (state == IDLE && start) begin
        state <= STREAM;
        idx <= '0;
        cur_ch <= INTERLEAVE == POS_MAJOR ? '0 : grant_idx;
      end else if (state == STREAM && xfer) begin
        if (last_o) begin
          state <= IDLE;
          rr_ptr <= INTERLEAVE == POS_MAJOR ? rr_ptr : ch_end ? '0 : cur_ch + 1'b1;
        end else if (INTERLEAVE == POS_MAJOR) begin
          cur_ch <= ch_end ? '0 : cur_ch + 1'b1;
          idx <= ch_end ? idx + 1'b1 : idx;
        end else
          idx <= idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_multi_channel_serializer.sv
// tb_multi_channel_serializer: directed checks of both ordering modes with N=4, H=3, W=16
module tb_multi_channel_serializer;
  localparam int N = 4;
  localparam int H = 3;
  localparam int W = 16;
  logic clk = 0;
  logic reset_i = 1;
  logic [N-1:0] valid_a = '0, valid_b = '0, ready_a, ready_b;
  logic [N-1:0][H-1:0][W-1:0] data_a = '0, data_b = '0;
  logic full_a = 0, full_b = 0, wen_a, wen_b, last_a, last_b;
  logic [W-1:0] dout_a, dout_b;
  logic [1:0] chan_a, chan_b, idx_a, idx_b;
  int checks = 0;
  int errors = 0;
  typedef struct {int ch; int idx; logic [W-1:0] d; bit last;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  multi_channel_serializer #(.NUM_CHANNELS(N), .LAYER_HEIGHT(H), .WORD_SIZE(W), .INTERLEAVE(0)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_a), .ready_o(ready_a), .data_i(data_a),
    .wen_o(wen_a), .full_i(full_a), .data_o(dout_a), .channel_o(chan_a), .index_o(idx_a), .last_o(last_a)
  );
  multi_channel_serializer #(.NUM_CHANNELS(N), .LAYER_HEIGHT(H), .WORD_SIZE(W), .INTERLEAVE(1)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_b), .ready_o(ready_b), .data_i(data_b),
    .wen_o(wen_b), .full_i(full_b), .data_o(dout_b), .channel_o(chan_b), .index_o(idx_b), .last_o(last_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  function automatic logic [W-1:0] w(input int g, input int c, input int i);
    return W'(g * 256 + c * 16 + i);
  endfunction
  task automatic load(input logic [N-1:0] v);
    valid_a = v;
    cyc();
    valid_a = '0;
  endtask
  task automatic push_frame(input int c, input int from);
    for (int i = from; i < H; i++) q.push_back('{c, i, data_a[c][i], i == H - 1});
  endtask
  task automatic drain(input bit b, input int exp_n);
    int n;
    exp_t e;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      if (n > 0) cyc();
      n++;
      if (b ? (wen_b && !full_b) : (wen_a && !full_a)) begin
        e = q.pop_front();
        check("channel", b ? chan_b : chan_a, e.ch);
        check("index", b ? idx_b : idx_a, e.idx);
        check("data", b ? dout_b : dout_a, e.d);
        check("last", b ? last_b : last_a, e.last);
      end
    end
    check("drain_left", q.size(), 0);
    check("drain_cycles", n, exp_n);
    q.delete();
  endtask
  initial begin
    cyc();
    cyc();
    check("rst_wen", wen_a, 0);
    check("rst_ready", ready_a, 0);
    check("rst_data", dout_a, 0);
    check("rst_chan", chan_a, 0);
    check("rst_idx", idx_a, 0);
    check("rst_last", last_a, 0);
    reset_i = 0;
    #1;
    check("rel_ready", ready_a, 4'b1111);
    check("rel_wen", wen_a, 0);
    cyc();
    for (int c = 0; c < N; c++) for (int i = 0; i < H; i++) data_a[c][i] = w(1, c, i);
    load(4'b1111);
    for (int c = 0; c < N; c++) push_frame(c, 0);
    for (int c = 0; c < N; c++) for (int i = 0; i < H; i++) data_a[c][i] = 16'hdead;
    drain(0, 16);
    cyc();
    for (int i = 0; i < H; i++) data_a[1][i] = w(2, 1, i);
    load(4'b0010);
    push_frame(1, 0);
    drain(0, 4);
    cyc();
    for (int i = 0; i < H; i++) begin
      data_a[1][i] = w(3, 1, i);
      data_a[3][i] = w(3, 3, i);
    end
    load(4'b1010);
    push_frame(3, 0);
    push_frame(1, 0);
    drain(0, 8);
    cyc();
    for (int i = 0; i < H; i++) data_a[2][i] = W'(i + 1);
    load(4'b0100);
    check("t_ready2", ready_a[2], 0);
    check("t_wen", wen_a, 0);
    for (int i = 0; i < H; i++) begin
      cyc();
      check("s_wen", wen_a, 1);
      check("s_data", dout_a, i + 1);
      check("s_chan", chan_a, 2);
      check("s_idx", idx_a, i);
      check("s_last", last_a, i == H - 1);
    end
    cyc();
    check("s_end_wen", wen_a, 0);
    check("s_end_ready", ready_a, 4'b1111);
    for (int i = 0; i < H; i++) data_a[0][i] = w(4, 0, i);
    load(4'b0001);
    cyc();
    check("bp_w0", dout_a, w(4, 0, 0));
    check("bp_w0_idx", idx_a, 0);
    cyc();
    check("bp_w1_idx", idx_a, 1);
    full_a = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("bp_wen", wen_a, 1);
      check("bp_data", dout_a, w(4, 0, 1));
      check("bp_idx", idx_a, 1);
      check("bp_last", last_a, 0);
    end
    full_a = 0;
    push_frame(0, 1);
    drain(0, 2);
    cyc();
    check("bp_end_wen", wen_a, 0);
    for (int i = 0; i < H; i++) data_a[2][i] = w(5, 2, i);
    load(4'b0100);
    push_frame(2, 0);
    valid_a = 4'b0100;
    for (int i = 0; i < H; i++) data_a[2][i] = w(6, 2, i);
    drain(0, 4);
    cyc();
    check("b2b_ready", ready_a, 4'b1111);
    check("b2b_gap", wen_a, 0);
    cyc();
    valid_a = '0;
    check("b2b_recap", ready_a[2], 0);
    push_frame(2, 0);
    drain(0, 4);
    cyc();
    for (int c = 0; c < N; c++) for (int i = 0; i < H; i++) data_b[c][i] = W'(c * 16 + i);
    valid_b = 4'b0111;
    cyc();
    valid_b = '0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("il_wait_wen", wen_b, 0);
    end
    check("il_wait_ready", ready_b, 4'b1000);
    valid_b = 4'b1000;
    cyc();
    valid_b = '0;
    for (int i = 0; i < H; i++)
      for (int c = 0; c < N; c++) q.push_back('{c, i, data_b[c][i], c == N - 1 && i == H - 1});
    drain(1, 13);
    cyc();
    check("il_ready", ready_b, 4'b1111);
    check("il_end_wen", wen_b, 0);
    for (int i = 0; i < H; i++) data_a[0][i] = w(7, 0, i);
    load(4'b0001);
    cyc();
    cyc();
    check("rm_idx", idx_a, 1);
    #1;
    reset_i = 1;
    #1;
    check("rm_wen", wen_a, 0);
    check("rm_ready", ready_a, 0);
    check("rm_data", dout_a, 0);
    check("rm_last", last_a, 0);
    cyc();
    reset_i = 0;
    cyc();
    check("rm_rel_ready", ready_a, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("rm_idle_wen", wen_a, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
